decode_stage_hz: RTL and testbench

Parametrised next-generation decode stage for the pipelined DLX-style core. It holds the IF/ID and ID/EX pipeline registers and the integer register file with write-through bypass. It also detects load-use hazards, holds IF/ID and inserts an ID/EX bubble when one occurs, and supports flush for taken branches and jumps. It sits between ifetch and execute, and takes its write port from writeback.

---
 rtl/decode_stage_hz.sv | 135 +++++++++++++
 tb/tb_decode_stage_hz.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hz.sv
// DLX decode stage: IF/ID and ID/EX registers plus a bypassed register file. Results appear one edge after IF/ID.
// A load-use hazard holds IF/ID and puts a bubble into ID/EX for one cycle. External stall holds both registers.
module decode_stage_hz #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int IMM_W    = 16,
  parameter int OP_W     = 6,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [OP_W-1:0]   if_opcode,
  input  logic [OP_W-1:0]   if_funct,
  input  logic [REG_AW-1:0] if_rs1,
  input  logic [REG_AW-1:0] if_rs2,
  input  logic [REG_AW-1:0] if_rd,
  input  logic [IMM_W-1:0]  if_imm,
  input  logic [31:0]       if_pc4,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_mem_read,
  output logic              hazard_stall,
  output logic              id_valid,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_opcode,
  output logic [OP_W-1:0]   ex_funct,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [IMM_W-1:0]  ex_imm,
  output logic [31:0]       ex_pc4,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b
);

  localparam int NREG = 1 << REG_AW;
  localparam bit ZR   = (ZERO_REG != 0);

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [OP_W-1:0]   funct;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [IMM_W-1:0]  imm;
    logic [31:0]       pc4;
  } instr_t;

  logic [DATA_W-1:0] rf [NREG];
  instr_t            if_instr;
  instr_t            id_q;
  instr_t            ex_q;
  logic [DATA_W-1:0] ex_a_q;
  logic [DATA_W-1:0] ex_b_q;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              load_use;

  assign if_instr = '{opcode: if_opcode, funct: if_funct, rs1: if_rs1, rs2: if_rs2,
                      rd: if_rd, imm: if_imm, pc4: if_pc4};

  always_comb begin
    load_use = id_valid && ex_valid && ex_mem_read &&
               !(ZR && ex_q.rd == '0) &&
               (ex_q.rd == id_q.rs1 || ex_q.rd == id_q.rs2);
  end

  assign hazard_stall = load_use && !flush && !reset;

  // Writeback data is forwarded so an instruction never reads a stale value in the write cycle.
  always_comb begin
    rd_a = rf[id_q.rs1];
    if (wb_we && wb_addr == id_q.rs1) rd_a = wb_data;
    if (ZR && id_q.rs1 == '0) rd_a = '0;
    rd_b = rf[id_q.rs2];
    if (wb_we && wb_addr == id_q.rs2) rd_b = wb_data;
    if (ZR && id_q.rs2 == '0) rd_b = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && !(ZR && wb_addr == '0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_q     <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (!stall && !load_use) begin
      id_valid <= if_valid;
      id_q     <= if_instr;
    end
  end

  // A bubble only clears the valid bit; the held fields are harmless once invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
      ex_a_q   <= '0;
      ex_b_q   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (!stall) begin
      if (load_use) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid <= id_valid;
        ex_q     <= id_q;
        ex_a_q   <= rd_a;
        ex_b_q   <= rd_b;
      end
    end
  end

  assign ex_opcode = ex_q.opcode;
  assign ex_funct  = ex_q.funct;
  assign ex_rs1    = ex_q.rs1;
  assign ex_rs2    = ex_q.rs2;
  assign ex_rd     = ex_q.rd;
  assign ex_imm    = ex_q.imm;
  assign ex_pc4    = ex_q.pc4;
  assign ex_a      = ex_a_q;
  assign ex_b      = ex_b_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Bench for decode_stage_hz: directed vector table followed by randomized traffic against a slot-based model.
module tb_decode_stage_hz;

  logic        clk = 1'b0;
  logic        reset, stall, flush, if_valid;
  logic [5:0]  if_opcode, if_funct;
  logic [4:0]  if_rs1, if_rs2, if_rd;
  logic [15:0] if_imm;
  logic [31:0] if_pc4;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic        hazard_stall, id_valid, ex_valid;
  logic [5:0]  ex_opcode, ex_funct;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [15:0] ex_imm;
  logic [31:0] ex_pc4, ex_a, ex_b;

  always #5 clk = ~clk;

  decode_stage_hz #(.DATA_W(32), .REG_AW(5), .IMM_W(16), .OP_W(6), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .if_valid(if_valid),
    .if_opcode(if_opcode), .if_funct(if_funct), .if_rs1(if_rs1), .if_rs2(if_rs2),
    .if_rd(if_rd), .if_imm(if_imm), .if_pc4(if_pc4), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_mem_read(ex_mem_read), .hazard_stall(hazard_stall),
    .id_valid(id_valid), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_a(ex_a), .ex_b(ex_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stl, fl, iv;
    logic [4:0]  rd, rs1, rs2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mr;
    logic        ehz, eidv, eexv, chk;
    logic [4:0]  erd;
    logic [31:0] ea, eb;
  } vec_t;

  function automatic vec_t mk(input logic rst, stl, fl, iv, input int rd, rs1, rs2,
                              input logic we, input int wa, input logic [31:0] wd, input logic mr,
                              input logic ehz, eidv, eexv, ck, input int erd,
                              input logic [31:0] ea, eb);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fl = fl; v.iv = iv;
    v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.we = we; v.wa = 5'(wa); v.wd = wd; v.mr = mr;
    v.ehz = ehz; v.eidv = eidv; v.eexv = eexv; v.chk = ck;
    v.erd = 5'(erd); v.ea = ea; v.eb = eb;
    return v;
  endfunction

  typedef struct {
    logic        v;
    logic [5:0]  op, fn;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] imm;
    logic [31:0] pc4, a, b;
  } slot_t;

  slot_t       m_id, m_ex;
  logic [31:0] m_rf [32];

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  vec_t tbl[$];

  initial begin
    {reset, stall, flush, if_valid, wb_we, ex_mem_read} = '0;
    {if_opcode, if_funct, if_rs1, if_rs2, if_rd, if_imm, if_pc4, wb_addr, wb_data} = '0;

    //          rst stl fl iv  rd rs1 rs2  we wa wd            mr  hz idv exv ck erd ea            eb
    tbl.push_back(mk(1,0,0,0,  0, 0, 0,  0,0,32'h0,        0,  0,0,0,1,  0, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0,  1,3,32'hAA,       0,  0,0,0,0,  0, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,1,  4, 3, 0,  0,0,32'h0,        0,  0,1,0,0,  0, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0,  0,0,32'h0,        0,  0,0,1,1,  4, 32'hAA,      32'h0));
    tbl.push_back(mk(0,0,0,1,  8, 7, 3,  0,0,32'h0,        0,  0,1,0,0,  0, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0,  1,7,32'h12345678, 0,  0,0,1,1,  8, 32'h12345678,32'hAA));
    tbl.push_back(mk(0,0,0,1,  5, 3, 0,  0,0,32'h0,        0,  0,1,0,0,  0, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,1,  6, 0, 5,  0,0,32'h0,        0,  0,1,1,1,  5, 32'hAA,      32'h0));
    tbl.push_back(mk(0,0,0,1,  9, 1, 2,  0,0,32'h0,        1,  1,1,0,1,  5, 32'hAA,      32'h0));
    tbl.push_back(mk(0,0,0,1,  9, 1, 2,  1,5,32'h55,       0,  0,1,1,1,  6, 32'h0,       32'h55));
    tbl.push_back(mk(0,0,0,1, 10, 0, 0,  0,0,32'h0,        0,  0,1,1,1,  9, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,1, 11,10, 0,  0,0,32'h0,        0,  0,1,1,1, 10, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,1,1,  1, 1, 1,  0,0,32'h0,        1,  0,0,0,0,  0, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,1, 12, 0, 0,  1,0,32'hFFFFFFFF, 0,  0,1,0,0,  0, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,1,  0, 3, 0,  1,0,32'hFFFFFFFF, 0,  0,1,1,1, 12, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,1, 13, 0, 0,  0,0,32'h0,        0,  0,1,1,1,  0, 32'hAA,      32'h0));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0,  0,0,32'h0,        1,  0,0,1,1, 13, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,1, 14, 3, 7,  0,0,32'h0,        0,  0,1,0,0,  0, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,1, 15, 5, 3,  0,0,32'h0,        0,  0,1,1,1, 14, 32'hAA,      32'h12345678));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,1,0,1, 16+k, k, k+1, 0,0,32'h0,   0,  0,1,1,1, 14, 32'hAA,      32'h12345678));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0,  0,0,32'h0,        0,  0,0,1,1, 15, 32'h55,      32'hAA));
    tbl.push_back(mk(0,0,0,1, 20, 0, 0,  0,0,32'h0,        0,  0,1,0,0,  0, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,1, 21,20, 0,  0,0,32'h0,        0,  0,1,1,1, 20, 32'h0,       32'h0));
    tbl.push_back(mk(0,1,0,1, 22, 0, 0,  0,0,32'h0,        1,  1,1,1,1, 20, 32'h0,       32'h0));
    tbl.push_back(mk(1,0,0,1, 22, 0, 0,  0,0,32'h0,        1,  0,0,0,1,  0, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,1,  1, 3, 5,  0,0,32'h0,        1,  0,1,0,1,  0, 32'h0,       32'h0));
    tbl.push_back(mk(0,0,0,0,  0, 0, 0,  0,0,32'h0,        0,  0,0,1,1,  1, 32'h0,       32'h0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; stall = tbl[i].stl; flush = tbl[i].fl; if_valid = tbl[i].iv;
      if_rd = tbl[i].rd; if_rs1 = tbl[i].rs1; if_rs2 = tbl[i].rs2;
      if_opcode = 6'h20; if_funct = 6'h0; if_imm = 16'(tbl[i].rd); if_pc4 = 32'(tbl[i].rd) << 2;
      wb_we = tbl[i].we; wb_addr = tbl[i].wa; wb_data = tbl[i].wd; ex_mem_read = tbl[i].mr;
      #1;
      chk($sformatf("row%0d_hazard_stall", i), 32'(hazard_stall), 32'(tbl[i].ehz));
      @(posedge clk); #1;
      chk($sformatf("row%0d_id_valid", i), 32'(id_valid), 32'(tbl[i].eidv));
      chk($sformatf("row%0d_ex_valid", i), 32'(ex_valid), 32'(tbl[i].eexv));
      if (tbl[i].chk) begin
        chk($sformatf("row%0d_ex_rd", i), 32'(ex_rd), 32'(tbl[i].erd));
        chk($sformatf("row%0d_ex_a", i), ex_a, tbl[i].ea);
        chk($sformatf("row%0d_ex_b", i), ex_b, tbl[i].eb);
      end
    end

    // Randomized traffic; the first cycle forces reset so the model starts aligned.
    for (int c = 0; c < 3000; c++) begin
      logic  lu;
      slot_t nid, nex;
      reset       = (c == 0) || ($urandom_range(63) == 0);
      stall       = ($urandom_range(4) == 0);
      flush       = ($urandom_range(7) == 0);
      if_valid    = ($urandom_range(3) != 0);
      if_opcode   = 6'($urandom);
      if_funct    = 6'($urandom);
      if_rs1      = 5'($urandom_range(7));
      if_rs2      = 5'($urandom_range(7));
      if_rd       = 5'($urandom_range(7));
      if_imm      = 16'($urandom);
      if_pc4      = $urandom;
      wb_we       = $urandom_range(1) == 1;
      wb_addr     = 5'($urandom_range(7));
      wb_data     = $urandom;
      ex_mem_read = $urandom_range(1) == 1;
      #1;
      lu = (c != 0) && m_id.v && m_ex.v && ex_mem_read && m_ex.rd != 5'd0 &&
           (m_ex.rd == m_id.rs1 || m_ex.rd == m_id.rs2);
      chk("rnd_hazard_stall", 32'(hazard_stall), 32'(lu && !flush && !reset));

      nid = m_id;
      nex = m_ex;
      if (reset) begin
        nid = '{default: '0};
        nex = '{default: '0};
      end else begin
        if (flush) nex.v = 1'b0;
        else if (!stall && lu) nex.v = 1'b0;
        else if (!stall) begin
          nex   = m_id;
          nex.a = mread(m_id.rs1);
          nex.b = mread(m_id.rs2);
        end
        if (flush) nid.v = 1'b0;
        else if (!stall && !lu)
          nid = '{v: if_valid, op: if_opcode, fn: if_funct, rs1: if_rs1, rs2: if_rs2,
                  rd: if_rd, imm: if_imm, pc4: if_pc4, a: 32'd0, b: 32'd0};
      end
      if (reset) begin
        for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
      end else if (wb_we && wb_addr != 5'd0) begin
        m_rf[wb_addr] = wb_data;
      end
      m_id = nid;
      m_ex = nex;

      @(posedge clk); #1;
      chk("rnd_id_valid", 32'(id_valid), 32'(m_id.v));
      chk("rnd_ex_valid", 32'(ex_valid), 32'(m_ex.v));
      chk("rnd_ex_opcode", 32'(ex_opcode), 32'(m_ex.op));
      chk("rnd_ex_funct", 32'(ex_funct), 32'(m_ex.fn));
      chk("rnd_ex_rs1", 32'(ex_rs1), 32'(m_ex.rs1));
      chk("rnd_ex_rs2", 32'(ex_rs2), 32'(m_ex.rs2));
      chk("rnd_ex_rd", 32'(ex_rd), 32'(m_ex.rd));
      chk("rnd_ex_imm", 32'(ex_imm), 32'(m_ex.imm));
      chk("rnd_ex_pc4", ex_pc4, m_ex.pc4);
      chk("rnd_ex_a", ex_a, m_ex.a);
      chk("rnd_ex_b", ex_b, m_ex.b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
